phy_reset_seq: RTL

Power-up and recovery reset sequencer for the board PHY and the core logic. Runs on the 50 MHz PLL output clock and watches the PLL lock flag. It drives the PHY reset pin and the system reset with guaranteed minimum pulse and settle times. A debounced push-button press restarts the PHY reset sequence at run time. It replaces the tied-high `phy_reset_n` in the top level.

---
 rtl/phy_reset_seq.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/phy_reset_seq.sv
// Power-up / recovery reset sequencer: waits for a stable PLL lock, pulses the PHY
// reset, lets the PHY settle, then releases the core reset. A debounced button press restarts the PHY reset.
module phy_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 2500000,
  parameter int PHY_RESET_CYCLES   = 500000,
  parameter int PHY_SETTLE_CYCLES  = 250000,
  parameter int DEBOUNCE_CYCLES    = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       button,
  output logic       phy_reset_n,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] seq_count
);

  localparam int MAX_LR  = (LOCK_STABLE_CYCLES > PHY_RESET_CYCLES) ? LOCK_STABLE_CYCLES : PHY_RESET_CYCLES;
  localparam int MAX_CYC = (MAX_LR > PHY_SETTLE_CYCLES) ? MAX_LR : PHY_SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CNT_W-1:0] L_TC   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_TC   = CNT_W'(PHY_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] S_TC   = CNT_W'(PHY_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
  localparam logic [DB_W-1:0]  DB_TC  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_1   = DB_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    LOCK_WAIT  = 3'd1,
    PHY_RESET  = 3'd2,
    PHY_SETTLE = 3'd3,
    RUN        = 3'd4
  } state_t;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              lock_p0, lock_p1;
  logic              btn_p0, btn_p1;
  logic              db_level, db_level_d;
  logic [DB_W-1:0]   db_cnt;
  logic              press;

  // Stage p0 -> p1: two-flop synchronizers for the asynchronous inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
    end else begin
      lock_p0 <= pll_locked;
      lock_p1 <= lock_p0;
      btn_p0  <= button;
      btn_p1  <= btn_p0;
    end
  end

  // Debounce: the level flips once the synced button has disagreed with it long enough
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level   <= 1'b0;
      db_level_d <= 1'b0;
      db_cnt     <= '0;
    end else begin
      db_level_d <= db_level;
      if (btn_p1 != db_level) begin
        if (db_cnt == DB_TC) begin
          db_level <= btn_p1;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = db_level & ~db_level_d;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (state_q != WAIT_LOCK && !lock_p1) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_p1) begin
            state_nxt = LOCK_WAIT;
            cnt_nxt   = '0;
          end
        end
        LOCK_WAIT: begin
          if (cnt_q == L_TC) begin
            state_nxt = PHY_RESET;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_1;
          end
        end
        PHY_RESET: begin
          if (press) begin
            cnt_nxt = '0;
          end else if (cnt_q == R_TC) begin
            state_nxt = PHY_SETTLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_1;
          end
        end
        PHY_SETTLE: begin
          if (press) begin
            state_nxt = PHY_RESET;
            cnt_nxt   = '0;
          end else if (cnt_q == S_TC) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_1;
          end
        end
        RUN: begin
          if (press) begin
            state_nxt = PHY_RESET;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they move on the same edge as state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      phy_reset_n <= 1'b0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      seq_count   <= 8'd0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      phy_reset_n <= (state_nxt == PHY_SETTLE) || (state_nxt == RUN);
      sys_reset_n <= (state_nxt == RUN);
      ready       <= (state_nxt == RUN);
      if (state_q == PHY_SETTLE && state_nxt == RUN && seq_count != 8'hFF)
        seq_count <= seq_count + 8'd1;
    end
  end

  assign state = state_q;

endmodule
